dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data-memory port (dmem) between two masters:
//  - port C: the rv32i_sc core load/store path.
//  - port X: an auxiliary master (program loader / debug / DMA).
//  - Round-robin arbitration, plus an X-side bus lock with a bounded hold time.
//  - Registered read-data return.
//  - Sits between rv32i_sc/aux master and dmem in top; core stalls while c_req && !c_gnt.
// PARAMETERS
//  LOCK_MAX  16  max consecutive cycles X may hold the lock (>=1)
//  CNT_W     32  width of grant statistics counters (ARB_STATS_EN only)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   asynchronous, active-high reset
//  c_req      in   1   core request; hold with stable payload until c_gnt
//  c_we       in   1   core write (1) / read (0)
//  c_addr     in   32  core byte address
//  c_wdata    in   32  core write data
//  c_size     in   3   core access size/sign code, passed to dmem MemSize
//  c_gnt      out  1   core request accepted this cycle
//  c_rvalid   out  1   core read data valid (cycle after read grant)
//  c_rdata    out  32  core read data
//  x_req/x_we/x_addr/x_wdata/x_size  in  1/1/32/32/3  aux request, same rules as C
//  x_lock     in   1   aux requests exclusive ownership while high
//  x_gnt      out  1   aux request accepted this cycle
//  x_rvalid   out  1   aux read data valid
//  x_rdata    out  32  aux read data
//  mem_we     out  1   to dmem we
//  mem_a      out  32  to dmem a
//  mem_wd     out  32  to dmem wd
//  mem_size   out  3   to dmem MemSize
//  mem_rd     in   32  from dmem rd (combinational read)
// BEHAVIOUR
//  - Reset: c_gnt=x_gnt=0, rvalid=0, rdata=0, FSM=IDLE, last=X, lock_cnt=0; in-flight rvalid dropped.
//  - Grant path: combinational from registered state and current reqs; zero-latency grant.
//    - mem_* driven from winner; all mem_* = 0 when no grant.
//    - mem_we = winner_we & gnt.
//  - Read return:
//    - On a granted read, mem_rd is registered into the winner's rdata.
//    - Winner's rvalid is 1 for exactly the next cycle.
//    - Writes never raise rvalid.
//    - The other port's rdata holds its previous value.
//  - Arbitration in IDLE:
//    - Single requester wins.
//    - Both requesting: the port != last wins.
//    - last <= winner on every grant.
//  - FSM IDLE -> LOCKED: when X is granted with x_lock=1; lock_cnt <= 1.
//  - FSM LOCKED:
//    - Only X may be granted; c_gnt=0.
//    - lock_cnt increments each cycle, saturating at LOCK_MAX.
//    - x_lock=0 -> IDLE.
//    - lock_cnt==LOCK_MAX while x_lock=1 -> RELEASE (forced).
//  - FSM RELEASE (1 cycle):
//    - C has absolute priority if c_req; else X may be granted.
//    - x_lock is ignored; next state is always IDLE.
//  - Simultaneous x_lock rise and C-wins tie in IDLE: C served, lock not taken.
//  - Never both grants in one cycle; no combinational path from mem_rd to any gnt.
// CONFIGURATION
//  ARB_STATS_EN defined:
//    - Adds outputs c_gnt_cnt, x_gnt_cnt [CNT_W-1:0], each +1 per grant.
//    - Wrap at 2^CNT_W; cleared by rst.
//  ARB_STATS_EN undefined: those ports and counters do not exist; arbitration identical.
// TESTING
//  - Reset: rst=1 mid-read grant -> next cycle all gnt/rvalid=0, mem_we=0, FSM IDLE.
//  - Tie: c_req=x_req=1 reads for 4 cycles after reset -> grants alternate C,X,C,X;
//    c_rvalid/x_rvalid one cycle after each own grant.
//  - Write pass: c_req,c_we=1,addr=0x100,wdata=0xDEADBEEF,size=2 ->
//    mem_we=1, mem_a=0x100, mem_wd=0xDEADBEEF same cycle; no rvalid.
//  - Lock bound: LOCK_MAX=4, x_lock and c_req held high ->
//    X granted 4 cycles, then C granted in RELEASE, then round-robin.
//  - Lock exit: x_lock drops after 2 cycles -> IDLE; C granted the next cycle.
//  - Stats (ARB_STATS_EN): 3 C grants + 5 X grants -> c_gnt_cnt=3, x_gnt_cnt=5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master (core C / aux X) arbiter for the single dmem port: round-robin with a bounded X-side lock.
// Optional grant statistics counters are built when ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  input  logic [2:0]  c_size,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  input  logic        x_req,
  input  logic        x_we,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wdata,
  input  logic [2:0]  x_size,
  input  logic        x_lock,
  output logic        x_gnt,
  output logic        x_rvalid,
  output logic [31:0] x_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic [2:0]  mem_size,
  input  logic [31:0] mem_rd
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] c_gnt_cnt,
  output logic [CNT_W-1:0] x_gnt_cnt
`endif
);

  localparam int unsigned CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_C = CW'(LOCK_MAX);

  if (LOCK_MAX < 1 || CNT_W < 1) begin : g_bad_param
    $error("dmem_arbiter: LOCK_MAX and CNT_W must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOCKED, S_RELEASE} state_e;
  typedef enum logic {PORT_C, PORT_X} port_e;

  state_e        state_q;
  port_e         last_q;
  logic [CW-1:0] lock_cnt_q;
  logic [CW-1:0] lock_cnt_d;

  logic        c_rvalid_q, x_rvalid_q;
  logic [31:0] c_rdata_q, x_rdata_q;

  // Grants depend only on registered state and current requests.
  always_comb begin
    c_gnt = 1'b0;
    x_gnt = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (c_req && x_req) begin
            if (last_q == PORT_X) c_gnt = 1'b1;
            else                  x_gnt = 1'b1;
          end else begin
            c_gnt = c_req;
            x_gnt = x_req;
          end
        end
        S_LOCKED:  x_gnt = x_req;
        S_RELEASE: begin
          c_gnt = c_req;
          x_gnt = x_req & ~c_req;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    mem_size = '0;
    if (c_gnt) begin
      mem_we   = c_we;
      mem_a    = c_addr;
      mem_wd   = c_wdata;
      mem_size = c_size;
    end else if (x_gnt) begin
      mem_we   = x_we;
      mem_a    = x_addr;
      mem_wd   = x_wdata;
      mem_size = x_size;
    end
  end

  assign lock_cnt_d = (lock_cnt_q == LOCK_C) ? lock_cnt_q : lock_cnt_q + CW'(1);

  // lock_cnt counts X-held cycles including the IDLE grant that took the lock;
  // the lock is released once the count reaches LOCK_MAX, giving exactly LOCK_MAX X grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= PORT_X;
      lock_cnt_q <= '0;
    end else begin
      if (c_gnt)      last_q <= PORT_C;
      else if (x_gnt) last_q <= PORT_X;
      unique case (state_q)
        S_IDLE: begin
          if (x_gnt && x_lock) begin
            lock_cnt_q <= CW'(1);
            state_q    <= (LOCK_MAX == 1) ? S_RELEASE : S_LOCKED;
          end
        end
        S_LOCKED: begin
          lock_cnt_q <= lock_cnt_d;
          if (!x_lock)                  state_q <= S_IDLE;
          else if (lock_cnt_d == LOCK_C) state_q <= S_RELEASE;
        end
        S_RELEASE: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_rvalid_q <= 1'b0;
      x_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      x_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= c_gnt & ~c_we;
      x_rvalid_q <= x_gnt & ~x_we;
      if (c_gnt && !c_we) c_rdata_q <= mem_rd;
      if (x_gnt && !x_we) x_rdata_q <= mem_rd;
    end
  end

  assign c_rvalid = c_rvalid_q;
  assign x_rvalid = x_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign x_rdata  = x_rdata_q;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] c_cnt_q, x_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_cnt_q <= '0;
      x_cnt_q <= '0;
    end else begin
      if (c_gnt) c_cnt_q <= c_cnt_q + CNT_W'(1);
      if (x_gnt) x_cnt_q <= x_cnt_q + CNT_W'(1);
    end
  end

  assign c_gnt_cnt = c_cnt_q;
  assign x_gnt_cnt = x_cnt_q;
`endif

endmodule
